// File: rtl/io_resp_pkg.sv
// Shared definitions for io_bus_responder: register offsets, CTRL/STATUS bit
// positions and the bus-cycle FSM state type.
package io_resp_pkg;

  localparam logic [2:0] OFF_ID      = 3'd0;
  localparam logic [2:0] OFF_SCRATCH = 3'd1;
  localparam logic [2:0] OFF_CTRL    = 3'd2;
  localparam logic [2:0] OFF_STATUS  = 3'd3;
  localparam logic [2:0] OFF_LOAD    = 3'd4;
  localparam logic [2:0] OFF_COUNT   = 3'd5;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_AUTO    = 2;
  localparam int STAT_EXPIRED = 0;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;

endpackage

// File: rtl/io_bus_responder_if.sv
// I/O bridge bus bundle; master is the bridge side, slave is the responder.
interface io_bus_responder_if;

  logic [15:0] io_address;
  logic        io_bus_enable;
  logic [1:0]  io_byte_enable;
  logic        io_rw;
  logic [15:0] io_write_data;
  logic [15:0] io_read_data;
  logic        io_acknowledge;
  logic        io_irq;

  modport master (
    output io_address, io_bus_enable, io_byte_enable, io_rw, io_write_data,
    input  io_read_data, io_acknowledge, io_irq
  );

  modport slave (
    input  io_address, io_bus_enable, io_byte_enable, io_rw, io_write_data,
    output io_read_data, io_acknowledge, io_irq
  );

endinterface

// File: rtl/io_resp_timer.sv
// Prescaled down-counter: produces a one-cycle expire strobe when a tick
// lands on COUNT == 0, and reloads COUNT from LOAD on start or auto-reload.
module io_resp_timer #(
  parameter int PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        enable,
  input  logic        auto_reload,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] load,
  output logic [15:0] count,
  output logic        expire
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc_reg;
  logic [15:0]   count_reg;
  logic          tick;

  // A stopping CTRL write suppresses the tick so it can never set expired.
  assign tick   = enable && !stop && (presc_reg == PW'(PRESCALE - 1));
  assign expire = tick && (count_reg == 16'd0);
  assign count  = count_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      presc_reg <= '0;
      count_reg <= '0;
    end else if (start) begin
      presc_reg <= '0;
      count_reg <= load;
    end else if (enable && !stop) begin
      if (tick) begin
        presc_reg <= '0;
        if (count_reg == 16'd0) begin
          if (auto_reload) count_reg <= load;
        end else begin
          count_reg <= count_reg - 16'd1;
        end
      end else begin
        presc_reg <= presc_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_bus_responder.sv
// Memory-mapped responder for the HPS/Nios I/O bridge: ID, scratch and an
// optional timer block, built when IO_RESP_TIMER_EN is defined.
module io_bus_responder
  import io_resp_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter logic [15:0] ID_VALUE    = 16'hA5C3,
  parameter int          WAIT_STATES = 1,
  parameter int          PRESCALE    = 50000
) (
  input logic              clk_clk,
  input logic              reset_reset,
  io_bus_responder_if.slave bus
);

  state_t      state_reg;
  logic [3:0]  wait_cnt_reg;
  logic        ack_reg;
  logic [15:0] rdata_reg;
  logic [15:0] rdata_next;
  logic [15:0] scratch_reg;
  logic        hit;
  logic        commit;
  logic        wr;
  logic [2:0]  offset;
  logic        unused_addr_bit;

  assign hit             = (bus.io_address[15:4] == BASE_ADDR[15:4]);
  assign offset          = bus.io_address[3:1];
  assign unused_addr_bit = bus.io_address[0];
  assign commit          = (state_reg == WAIT) && (wait_cnt_reg == 4'd0);
  assign wr              = commit && !bus.io_rw;

  assign bus.io_acknowledge = ack_reg;
  assign bus.io_read_data   = rdata_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_scratch_lane
      logic [7:0] lane_reg;
      always_ff @(posedge clk_clk) begin
        if (reset_reset)
          lane_reg <= 8'h00;
        else if (wr && offset == OFF_SCRATCH && bus.io_byte_enable[gi])
          lane_reg <= bus.io_write_data[gi*8 +: 8];
      end
      assign scratch_reg[gi*8 +: 8] = lane_reg;
    end
  endgenerate

`ifdef IO_RESP_TIMER_EN
  logic [2:0]  ctrl_reg;
  logic        expired_reg;
  logic        irq_reg;
  logic [15:0] load_reg;
  logic [15:0] count;
  logic        expire;
  logic        ctrl_wr;
  logic        start;
  logic        stop;
  logic        status_w1c;

  assign ctrl_wr    = wr && offset == OFF_CTRL && bus.io_byte_enable[0];
  assign start      = ctrl_wr && !ctrl_reg[CTRL_EN] && bus.io_write_data[CTRL_EN];
  assign stop       = ctrl_wr && !bus.io_write_data[CTRL_EN];
  assign status_w1c = wr && offset == OFF_STATUS && bus.io_byte_enable[0]
                      && bus.io_write_data[STAT_EXPIRED];

  generate
    for (gi = 0; gi < 2; gi++) begin : g_load_lane
      logic [7:0] lane_reg;
      always_ff @(posedge clk_clk) begin
        if (reset_reset)
          lane_reg <= 8'h00;
        else if (wr && offset == OFF_LOAD && bus.io_byte_enable[gi])
          lane_reg <= bus.io_write_data[gi*8 +: 8];
      end
      assign load_reg[gi*8 +: 8] = lane_reg;
    end
  endgenerate

  // Expiry set is evaluated after the W1C so a coincident clear loses.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      ctrl_reg    <= 3'b000;
      expired_reg <= 1'b0;
      irq_reg     <= 1'b0;
    end else begin
      if (ctrl_wr)
        ctrl_reg <= bus.io_write_data[2:0];
      else if (expire && !ctrl_reg[CTRL_AUTO])
        ctrl_reg[CTRL_EN] <= 1'b0;
      if (expire)
        expired_reg <= 1'b1;
      else if (status_w1c)
        expired_reg <= 1'b0;
      irq_reg <= expired_reg & ctrl_reg[CTRL_IRQ_EN];
    end
  end

  io_resp_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk         (clk_clk),
    .srst        (reset_reset),
    .enable      (ctrl_reg[CTRL_EN]),
    .auto_reload (ctrl_reg[CTRL_AUTO]),
    .start       (start),
    .stop        (stop),
    .load        (load_reg),
    .count       (count),
    .expire      (expire)
  );

  assign bus.io_irq = irq_reg;
`else
  assign bus.io_irq = 1'b0;
`endif

  always_comb begin
    rdata_next = 16'h0000;
    case (offset)
      OFF_ID:      rdata_next = ID_VALUE;
      OFF_SCRATCH: rdata_next = scratch_reg;
`ifdef IO_RESP_TIMER_EN
      OFF_CTRL:    rdata_next = {13'd0, ctrl_reg};
      OFF_STATUS:  rdata_next = {15'd0, expired_reg};
      OFF_LOAD:    rdata_next = load_reg;
      OFF_COUNT:   rdata_next = count;
`endif
      default:     rdata_next = 16'h0000;
    endcase
  end

  // HOLD waits for the bridge to drop enable so each request acks once.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= 4'd0;
      ack_reg      <= 1'b0;
      rdata_reg    <= 16'h0000;
    end else begin
      ack_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.io_bus_enable && hit) begin
            state_reg    <= WAIT;
            wait_cnt_reg <= 4'(WAIT_STATES);
          end
        end
        WAIT: begin
          if (wait_cnt_reg == 4'd0) begin
            state_reg <= ACK;
            ack_reg   <= 1'b1;
            if (bus.io_rw) rdata_reg <= rdata_next;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
        end
        ACK:  state_reg <= HOLD;
        HOLD: if (!bus.io_bus_enable) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_responder.sv
// Self-checking bench for io_bus_responder; timer tests run only when
// IO_RESP_TIMER_EN is defined, otherwise offsets 2-5 are checked as zero.
module tb_io_bus_responder;

  localparam logic [15:0] BASE    = 16'h0120;
  localparam logic [11:0] BASE_HI = 12'h012;
  localparam int          WS_A    = 1;
  localparam int          PRE_A   = 4;
  localparam int          WS_B    = 5;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  io_bus_responder_if bus_a ();
  io_bus_responder_if bus_b ();

  io_bus_responder #(.BASE_ADDR(BASE), .ID_VALUE(16'hA5C3), .WAIT_STATES(WS_A), .PRESCALE(PRE_A))
    dut_a (.clk_clk(clk), .reset_reset(rst_a), .bus(bus_a));
  io_bus_responder #(.BASE_ADDR(BASE), .ID_VALUE(16'hA5C3), .WAIT_STATES(WS_B), .PRESCALE(PRE_A))
    dut_b (.clk_clk(clk), .reset_reset(rst_b), .bus(bus_b));

  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;
  int          ack_at = -1;
  logic        mon_on = 1'b0;
  logic        req_rw = 1'b0;
  logic [2:0]  req_off = 3'd0;
  logic [1:0]  req_be = 2'b00;
  logic [15:0] req_wd = 16'h0000;
  logic        rd_known = 1'b1;
  logic [15:0] exp_rd = 16'h0000;
  logic [15:0] m_scratch = 16'h0000;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d want finish", cyc);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic model_knows(input logic [2:0] off);
`ifdef IO_RESP_TIMER_EN
    return !(off inside {3'd2, 3'd3, 3'd4, 3'd5});
`else
    return off != 3'd8 - 3'd8 || 1'b1;
`endif
  endfunction

  function automatic logic [15:0] model_read(input logic [2:0] off);
    case (off)
      3'd0:    return 16'hA5C3;
      3'd1:    return m_scratch;
      default: return 16'h0000;
    endcase
  endfunction

  // Per-cycle compare: ack only in the predicted cycle, read data holds last read.
  initial forever begin
    logic hit_now;
    @(negedge clk);
    if (mon_on) begin
      hit_now = (cyc == ack_at);
      check("ack", 32'(bus_a.io_acknowledge), 32'(hit_now));
      if (hit_now && req_rw) begin
        if (model_knows(req_off)) begin
          exp_rd   = model_read(req_off);
          rd_known = 1'b1;
        end else begin
          rd_known = 1'b0;
        end
      end
      if (rd_known) check("read_data", 32'(bus_a.io_read_data), 32'(exp_rd));
`ifndef IO_RESP_TIMER_EN
      check("irq_tied", 32'(bus_a.io_irq), 32'd0);
`endif
      if (hit_now && !req_rw && req_off == 3'd1) begin
        if (req_be[0]) m_scratch[7:0]  = req_wd[7:0];
        if (req_be[1]) m_scratch[15:8] = req_wd[15:8];
      end
    end
  end

  task automatic xfer(input logic [15:0] addr, input logic rw, input logic [15:0] wd,
                      input logic [1:0] be, input int hold, output logic [15:0] rd);
    logic seen;
    @(posedge clk); #1;
    bus_a.io_address     = addr;
    bus_a.io_rw          = rw;
    bus_a.io_write_data  = wd;
    bus_a.io_byte_enable = be;
    bus_a.io_bus_enable  = 1'b1;
    req_rw  = rw;
    req_off = addr[3:1];
    req_be  = be;
    req_wd  = wd;
    ack_at  = (addr[15:4] == BASE_HI) ? cyc + 2 + WS_A : -1;
    seen = 1'b0;
    rd   = 16'h0000;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (bus_a.io_acknowledge === 1'b1) begin
        seen = 1'b1;
        rd   = bus_a.io_read_data;
      end
    end
    if (ack_at >= 0) check("ack_seen", 32'(seen), 32'd1);
    repeat (hold) @(negedge clk);
    @(posedge clk); #1;
    bus_a.io_bus_enable = 1'b0;
    @(posedge clk);
  endtask

  task automatic wr_a(input logic [15:0] addr, input logic [15:0] wd, input logic [1:0] be);
    logic [15:0] dummy;
    xfer(addr, 1'b0, wd, be, 0, dummy);
  endtask

  task automatic rd_a(input logic [15:0] addr, output logic [15:0] rd);
    xfer(addr, 1'b1, 16'h0000, 2'b11, 0, rd);
  endtask

`ifdef IO_RESP_TIMER_EN
  task automatic wait_irq(input string name, output int rise);
    logic seen;
    seen = 1'b0;
    rise = -1;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus_a.io_irq === 1'b1) begin
        seen = 1'b1;
        rise = cyc;
      end
    end
    check(name, 32'(seen), 32'd1);
  endtask
`endif

  initial begin
    logic [15:0] rd;
    int first;
    int acks;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.io_address = 16'h0; bus_a.io_bus_enable = 1'b0; bus_a.io_byte_enable = 2'b00;
    bus_a.io_rw = 1'b0; bus_a.io_write_data = 16'h0;
    bus_b.io_address = 16'h0; bus_b.io_bus_enable = 1'b0; bus_b.io_byte_enable = 2'b00;
    bus_b.io_rw = 1'b0; bus_b.io_write_data = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    check("reset_ack_a", 32'(bus_a.io_acknowledge), 32'd0);
    check("reset_rd_a",  32'(bus_a.io_read_data),   32'd0);
    check("reset_irq_a", 32'(bus_a.io_irq),         32'd0);
    check("reset_ack_b", 32'(bus_b.io_acknowledge), 32'd0);
    check("reset_rd_b",  32'(bus_b.io_read_data),   32'd0);
    mon_on = 1'b1;

    rd_a(BASE, rd);
    check("id_literal", 32'(rd), 32'hA5C3);
    wr_a(BASE + 16'h2, 16'h1234, 2'b01);
    rd_a(BASE + 16'h2, rd);
    check("scratch_low_lane", 32'(rd), 32'h0034);
    wr_a(BASE + 16'h2, 16'hAB00, 2'b10);
    rd_a(BASE + 16'h3, rd);
    check("scratch_high_lane", 32'(rd), 32'hAB34);
    wr_a(BASE + 16'h2, 16'hFFFF, 2'b00);
    rd_a(BASE + 16'h2, rd);
    check("scratch_be_zero", 32'(rd), 32'hAB34);

    xfer(BASE + 16'h10, 1'b1, 16'h0, 2'b11, 0, rd);
    xfer(BASE + 16'h2, 1'b1, 16'h0, 2'b11, 10, rd);
    check("slow_bridge_rd", 32'(rd), 32'hAB34);

    for (int off = 6; off < 8; off++) begin
      wr_a(BASE + 16'(off * 2), 16'hFFFF, 2'b11);
      rd_a(BASE + 16'(off * 2), rd);
      check("reserved_zero", 32'(rd), 32'd0);
    end

`ifndef IO_RESP_TIMER_EN
    for (int off = 2; off < 6; off++) begin
      wr_a(BASE + 16'(off * 2), 16'hFFFF, 2'b11);
      rd_a(BASE + 16'(off * 2), rd);
      check("timer_absent_zero", 32'(rd), 32'd0);
    end
`else
    begin
      int ctrl_ack;
      int r1;
      int r2;
      wr_a(BASE + 16'h8, 16'd3, 2'b11);
      wr_a(BASE + 16'h4, 16'h0003, 2'b01);
      ctrl_ack = ack_at;
      wait_irq("one_shot_irq", r1);
      check("one_shot_delay", 32'(r1 - ctrl_ack), 32'd17);
      rd_a(BASE + 16'h4, rd);
      check("one_shot_ctrl", 32'(rd), 32'h0002);
      rd_a(BASE + 16'hA, rd);
      check("one_shot_count", 32'(rd), 32'h0000);
      rd_a(BASE + 16'h6, rd);
      check("one_shot_status", 32'(rd), 32'h0001);
      wr_a(BASE + 16'h6, 16'h0001, 2'b01);
      @(negedge clk);
      check("w1c_irq_low", 32'(bus_a.io_irq), 32'd0);

      wr_a(BASE + 16'h8, 16'd1, 2'b11);
      wr_a(BASE + 16'h4, 16'h0007, 2'b01);
      wait_irq("auto_irq1", r1);
      wr_a(BASE + 16'h6, 16'h0001, 2'b01);
      wait_irq("auto_irq2", r2);
      check("auto_period", 32'(r2 - r1), 32'd8);
      while (cyc < r2 + 3) @(negedge clk);
      wr_a(BASE + 16'h6, 16'h0001, 2'b01);
      rd_a(BASE + 16'h6, rd);
      check("w1c_vs_expiry", 32'(rd), 32'h0001);
      check("w1c_vs_expiry_irq", 32'(bus_a.io_irq), 32'd1);
      wr_a(BASE + 16'h4, 16'h0000, 2'b01);
      wr_a(BASE + 16'h6, 16'h0001, 2'b01);
      rd_a(BASE + 16'h6, rd);
      check("stopped_status", 32'(rd), 32'h0000);
    end
`endif

    // Second instance: reset asserted while the request sits in WAIT.
    @(posedge clk); #1;
    bus_b.io_address     = BASE;
    bus_b.io_rw          = 1'b1;
    bus_b.io_byte_enable = 2'b11;
    bus_b.io_bus_enable  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("b_wait_no_ack", 32'(bus_b.io_acknowledge), 32'd0);
    end
    rst_b = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    first = -1;
    acks  = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("b_reset_ack", 32'(bus_b.io_acknowledge), 32'd0);
        check("b_reset_rd",  32'(bus_b.io_read_data),   32'd0);
        check("b_reset_irq", 32'(bus_b.io_irq),         32'd0);
      end
      if (bus_b.io_acknowledge === 1'b1) begin
        acks++;
        if (first < 0) begin
          first = i;
          rd    = bus_b.io_read_data;
        end
      end
    end
    check("b_reissue_latency", 32'(first), 32'd8);
    check("b_reissue_acks", 32'(acks), 32'd1);
    check("b_reissue_rd", 32'(rd), 32'hA5C3);
    @(posedge clk); #1;
    bus_b.io_bus_enable = 1'b0;
    repeat (2) @(posedge clk);

    mon_on = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
